// File: rtl/temporal_decoder.sv
// temporal_decoder
// ----------------
// Converts a temporally coded input into a binary arrival time. A one-cycle
// start pulse opens a window of 2**BITS+1 cycles. During the window the block
// counts 0..2**BITS and records the count of the first cycle in which the
// active level (tsig XOR the polarity latched with start) is seen. At the end
// of the window the result is presented with valid until downstream accepts it.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : one-cycle pulse that opens a decode window
//   pol       : coding polarity, sampled with start (1 = tsig inverted)
//   tsig      : temporally coded input, synchronous to clk
//   ready     : downstream accepts the result when high together with valid
//   value     : decoded arrival time (saturates to 2**BITS-1)
//   none      : window closed without any active cycle
//   ovf       : active level first seen at the last count (2**BITS)
//   valid     : result available, held until accepted
//   busy      : window in progress
//   dbg_state : current FSM state (0 IDLE, 1 COUNT, 2 DONE)
//
// Handshake: a result transfers on a rising edge where valid and ready are
// both high. valid stays high and value/none/ovf stay stable until that edge;
// ready has no effect while valid is low.

module temporal_decoder #(
  parameter int BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            pol,
  input  logic            tsig,
  input  logic            ready,
  output logic [BITS-1:0] value,
  output logic            none,
  output logic            ovf,
  output logic            valid,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Final count of the window; the counter is one bit wider so it never wraps.
  localparam logic [BITS:0]   LAST = {1'b1, {BITS{1'b0}}};
  localparam logic [BITS-1:0] SAT  = {BITS{1'b1}};

  state_e          state_q, state_d;
  logic [BITS:0]   count_q, count_d;
  logic            pol_q, pol_d;
  logic            found_q, found_d;
  logic [BITS-1:0] cap_q, cap_d;
  logic [BITS-1:0] value_q, value_d;
  logic            none_q, none_d;
  logic            ovf_q, ovf_d;

  logic act;
  logic open_win;

  assign act = tsig ^ pol_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pol_d    = pol_q;
    found_d  = found_q;
    cap_d    = cap_q;
    value_d  = value_q;
    none_d   = none_q;
    ovf_d    = ovf_q;
    open_win = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) open_win = 1'b1;
      end

      S_COUNT: begin
        // Only the first active cycle counts; later transitions are ignored.
        if (!found_q && act) begin
          found_d = 1'b1;
          cap_d   = count_q[BITS-1:0];
        end
        if (count_q == LAST) begin
          state_d = S_DONE;
          if (found_q) begin
            // An earlier capture always happened below LAST, so it fits BITS.
            value_d = cap_q;
            none_d  = 1'b0;
            ovf_d   = 1'b0;
          end else if (act) begin
            value_d = SAT;
            none_d  = 1'b0;
            ovf_d   = 1'b1;
          end else begin
            value_d = SAT;
            none_d  = 1'b1;
            ovf_d   = 1'b0;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      S_DONE: begin
        if (ready) begin
          // Accepting with start in the same cycle chains windows back to back.
          if (start) open_win = 1'b1;
          else       state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (open_win) begin
      state_d = S_COUNT;
      pol_d   = pol;
      count_d = '0;
      found_d = 1'b0;
      cap_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      pol_q   <= 1'b0;
      found_q <= 1'b0;
      cap_q   <= '0;
      value_q <= '0;
      none_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pol_q   <= pol_d;
      found_q <= found_d;
      cap_q   <= cap_d;
      value_q <= value_d;
      none_q  <= none_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value     = value_q;
  assign none      = none_q;
  assign ovf       = ovf_q;
  assign valid     = (state_q == S_DONE);
  assign busy      = (state_q == S_COUNT);
  assign dbg_state = state_q;

endmodule
